// File: rtl/vm_customer_agent.sv
// Customer-side agent for vending_machine: replays host coins/selection to the VM, sinks product
// and change, and reports one summary per transaction (o_done pulse, totals held until next first coin).
module vm_customer_agent #(
  parameter int VALUE_W      = 20,
  parameter int BUSY_TIMEOUT = 64,
  parameter int COLLECT_MAX  = 1024
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_coin_code,
  input  logic               i_coin_valid,
  input  logic               i_coin_last,
  output logic               o_coin_ready,
  input  logic [2:0]         i_sel_product,
  output logic [3:0]         o_money,
  output logic               o_money_valid,
  output logic [2:0]         o_product_code,
  output logic               o_buy,
  input  logic               i_busy,
  input  logic [2:0]         i_product_code,
  input  logic               i_product_valid,
  output logic               o_product_ready,
  input  logic [3:0]         i_change_code,
  input  logic               i_change_valid,
  input  logic               i_no_change,
  output logic               o_done,
  output logic               o_got_product,
  output logic [2:0]         o_rx_product,
  output logic [VALUE_W-1:0] o_inserted_total,
  output logic [VALUE_W-1:0] o_change_total,
  output logic               o_no_change_seen,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE, S_INSERT, S_BUY, S_WAIT_BUSY, S_COLLECT, S_DONE
  } state_t;

  localparam int CNT_MAX = (COLLECT_MAX > BUSY_TIMEOUT) ? COLLECT_MAX : BUSY_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  function automatic logic [15:0] coin_cents(input logic [3:0] code);
    case (code)
      4'd0:    coin_cents = 16'd50000;
      4'd1:    coin_cents = 16'd20000;
      4'd2:    coin_cents = 16'd10000;
      4'd3:    coin_cents = 16'd5000;
      4'd4:    coin_cents = 16'd2000;
      4'd5:    coin_cents = 16'd1000;
      4'd6:    coin_cents = 16'd500;
      4'd7:    coin_cents = 16'd200;
      4'd8:    coin_cents = 16'd100;
      4'd9:    coin_cents = 16'd50;
      4'd10:   coin_cents = 16'd25;
      4'd11:   coin_cents = 16'd10;
      4'd12:   coin_cents = 16'd5;
      4'd13:   coin_cents = 16'd2;
      4'd14:   coin_cents = 16'd1;
      default: coin_cents = 16'd0;
    endcase
  endfunction

  function automatic logic [VALUE_W-1:0] sat_add(input logic [VALUE_W-1:0] acc,
                                                 input logic [15:0]        val);
    logic [VALUE_W:0] sum;
    sum = {1'b0, acc} + (VALUE_W+1)'(val);
    sat_add = sum[VALUE_W] ? '1 : sum[VALUE_W-1:0];
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         money_q, money_d;
  logic               money_vld_q, money_vld_d;
  logic               last_q, last_d;
  logic [2:0]         sel_q, sel_d;
  logic               got_q, got_d;
  logic [2:0]         rx_q, rx_d;
  logic [VALUE_W-1:0] ins_q, ins_d;
  logic [VALUE_W-1:0] chg_q, chg_d;
  logic               noch_q, noch_d;
  logic               tmo_q, tmo_d;
  // Holds coin_ready low until the first clock edge after reset release.
  logic               run_q;

  logic coin_rdy, coin_hs, prod_hs;

  assign coin_rdy = run_q && (state_q == S_IDLE || state_q == S_INSERT) && !i_busy && !money_vld_q;
  assign coin_hs  = coin_rdy && i_coin_valid;
  assign prod_hs  = (state_q == S_COLLECT) && i_product_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    money_d     = 4'd0;
    money_vld_d = 1'b0;
    last_d      = last_q;
    sel_d       = sel_q;
    got_d       = got_q;
    rx_d        = rx_q;
    ins_d       = ins_q;
    chg_d       = chg_q;
    noch_d      = noch_q;
    tmo_d       = tmo_q;

    if (coin_hs) begin
      money_d     = i_coin_code;
      money_vld_d = 1'b1;
      if (state_q == S_IDLE) begin
        // First coin opens a new transaction: previous summary is discarded here.
        ins_d  = sat_add('0, coin_cents(i_coin_code));
        chg_d  = '0;
        got_d  = 1'b0;
        rx_d   = 3'd0;
        noch_d = 1'b0;
        tmo_d  = 1'b0;
      end else begin
        ins_d = sat_add(ins_q, coin_cents(i_coin_code));
      end
      if (i_coin_last) begin
        last_d = 1'b1;
        sel_d  = i_sel_product;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (coin_hs) state_d = S_INSERT;
      end
      S_INSERT: begin
        if (money_vld_q && last_q) state_d = S_BUY;
      end
      S_BUY: begin
        last_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (i_no_change) noch_d = 1'b1;
        if (i_busy) begin
          cnt_d   = '0;
          state_d = S_COLLECT;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_COLLECT: begin
        if (prod_hs && !got_q) begin
          got_d = 1'b1;
          rx_d  = i_product_code;
        end
        if (i_change_valid) chg_d = sat_add(chg_q, coin_cents(i_change_code));
        if (i_no_change) noch_d = 1'b1;
        if (!i_busy && !i_product_valid) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(COLLECT_MAX - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      money_q     <= 4'd0;
      money_vld_q <= 1'b0;
      last_q      <= 1'b0;
      sel_q       <= 3'd0;
      got_q       <= 1'b0;
      rx_q        <= 3'd0;
      ins_q       <= '0;
      chg_q       <= '0;
      noch_q      <= 1'b0;
      tmo_q       <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      money_q     <= money_d;
      money_vld_q <= money_vld_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      got_q       <= got_d;
      rx_q        <= rx_d;
      ins_q       <= ins_d;
      chg_q       <= chg_d;
      noch_q      <= noch_d;
      tmo_q       <= tmo_d;
      run_q       <= 1'b1;
    end
  end

  assign o_coin_ready     = coin_rdy;
  assign o_money          = money_q;
  assign o_money_valid    = money_vld_q;
  assign o_buy            = (state_q == S_BUY);
  assign o_product_code   = (state_q == S_BUY || state_q == S_WAIT_BUSY ||
                             state_q == S_COLLECT || state_q == S_DONE) ? sel_q : 3'd0;
  assign o_product_ready  = prod_hs;
  assign o_done           = (state_q == S_DONE);
  assign o_got_product    = got_q;
  assign o_rx_product     = rx_q;
  assign o_inserted_total = ins_q;
  assign o_change_total   = chg_q;
  assign o_no_change_seen = noch_q;
  assign o_timeout        = tmo_q;

endmodule

// File: tb/tb_vm_customer_agent.sv
// Directed bench for vm_customer_agent: plays the host and VM sides cycle by cycle.
module tb_vm_customer_agent;
  localparam int VALUE_W = 20;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] coin_code;
  logic coin_valid, coin_last;
  logic [2:0] sel_product;
  logic busy;
  logic [2:0] vm_prod_code;
  logic vm_prod_valid;
  logic [3:0] change_code;
  logic change_valid, no_change;

  logic coin_ready, money_valid, buy, product_ready, done;
  logic [3:0] money;
  logic [2:0] product_code, rx_product;
  logic got_product, no_change_seen, timeout;
  logic [VALUE_W-1:0] inserted_total, change_total;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  vm_customer_agent dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_coin_code(coin_code), .i_coin_valid(coin_valid), .i_coin_last(coin_last),
    .o_coin_ready(coin_ready), .i_sel_product(sel_product),
    .o_money(money), .o_money_valid(money_valid),
    .o_product_code(product_code), .o_buy(buy), .i_busy(busy),
    .i_product_code(vm_prod_code), .i_product_valid(vm_prod_valid),
    .o_product_ready(product_ready),
    .i_change_code(change_code), .i_change_valid(change_valid), .i_no_change(no_change),
    .o_done(done), .o_got_product(got_product), .o_rx_product(rx_product),
    .o_inserted_total(inserted_total), .o_change_total(change_total),
    .o_no_change_seen(no_change_seen), .o_timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [3:0] code, input logic last, input logic [2:0] sel);
    coin_code = code; coin_valid = 1'b1; coin_last = last; sel_product = sel;
    #1;
    chk("coin_ready", {31'd0, coin_ready}, 32'd1);
    tick();
    coin_valid = 1'b0; coin_last = 1'b0;
    #1;
    chk("money_valid", {31'd0, money_valid}, 32'd1);
    chk("money_code", {28'd0, money}, {28'd0, code});
    tick();
    #1;
    chk("money_pulse_end", {31'd0, money_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; coin_code = 4'd0; coin_valid = 1'b0; coin_last = 1'b0; sel_product = 3'd0;
    busy = 1'b0; vm_prod_code = 3'd0; vm_prod_valid = 1'b0;
    change_code = 4'd0; change_valid = 1'b0; no_change = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_coin_ready", {31'd0, coin_ready}, 32'd0);
    chk("rst_money_valid", {31'd0, money_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_inserted", 32'(inserted_total), 32'd0);
    chk("rst_buy", {31'd0, buy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: coins {6,9}, sel 3, product 3 + change 50
    coin(4'd6, 1'b0, 3'd3);
    coin(4'd9, 1'b1, 3'd3);
    chk("t1_buy", {31'd0, buy}, 32'd1);
    chk("t1_buy_code", {29'd0, product_code}, 32'd3);
    chk("t1_inserted", 32'(inserted_total), 32'd550);
    tick();
    busy = 1'b1;
    #1;
    chk("t1_buy_one_cycle", {31'd0, buy}, 32'd0);
    chk("t1_code_hold", {29'd0, product_code}, 32'd3);
    tick();
    vm_prod_valid = 1'b1; vm_prod_code = 3'd3; change_valid = 1'b1; change_code = 4'd9;
    #1;
    chk("t1_product_ready", {31'd0, product_ready}, 32'd1);
    tick();
    vm_prod_valid = 1'b0; change_valid = 1'b0; busy = 1'b0;
    #1;
    chk("t1_not_done_yet", {31'd0, done}, 32'd0);
    tick();
    #1;
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_inserted_done", 32'(inserted_total), 32'd550);
    chk("t1_change", 32'(change_total), 32'd50);
    chk("t1_got", {31'd0, got_product}, 32'd1);
    chk("t1_rx", {29'd0, rx_product}, 32'd3);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    tick();
    #1;
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_summary_held", 32'(change_total), 32'd50);

    // 2: coin {2}, sel 0, change 200+50+25 with last change as busy falls
    coin(4'd2, 1'b1, 3'd0);
    chk("t2_inserted_cleared", 32'(inserted_total), 32'd10000);
    chk("t2_change_cleared", 32'(change_total), 32'd0);
    chk("t2_got_cleared", {31'd0, got_product}, 32'd0);
    tick();
    busy = 1'b1;
    tick();
    vm_prod_valid = 1'b1; vm_prod_code = 3'd0; change_valid = 1'b1; change_code = 4'd7;
    tick();
    vm_prod_valid = 1'b0; change_code = 4'd9;
    tick();
    change_code = 4'd10; busy = 1'b0;
    tick();
    change_valid = 1'b0;
    #1;
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_change", 32'(change_total), 32'd275);
    chk("t2_got", {31'd0, got_product}, 32'd1);
    chk("t2_rx", {29'd0, rx_product}, 32'd0);
    tick();

    // 3: busy never rises after buy
    coin(4'd8, 1'b1, 3'd1);
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("t3_done_latency", 32'(n), 32'd65);
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_got", {31'd0, got_product}, 32'd0);
    chk("t3_inserted", 32'(inserted_total), 32'd100);
    tick();

    // 4: no_change flagged, no change returned
    coin(4'd12, 1'b1, 3'd2);
    tick();
    busy = 1'b1;
    tick();
    vm_prod_valid = 1'b1; vm_prod_code = 3'd2; no_change = 1'b1;
    tick();
    vm_prod_valid = 1'b0; no_change = 1'b0; busy = 1'b0;
    tick();
    #1;
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_no_change", {31'd0, no_change_seen}, 32'd1);
    chk("t4_change", 32'(change_total), 32'd0);
    chk("t4_timeout_cleared", {31'd0, timeout}, 32'd0);
    chk("t4_rx", {29'd0, rx_product}, 32'd2);
    tick();

    // 5: coin held while VM busy
    busy = 1'b1; coin_valid = 1'b1; coin_code = 4'd6; coin_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_coin_ready", {31'd0, coin_ready}, 32'd0);
      chk("t5_money_valid", {31'd0, money_valid}, 32'd0);
      tick();
    end
    coin_valid = 1'b0; busy = 1'b0;
    #1;
    chk("t5_summary_held", 32'(inserted_total), 32'd5);
    tick();

    // Saturation: 21 x 50000 exceeds 2^20-1
    for (int i = 0; i < 21; i++) coin(4'd0, (i == 20), 3'd4);
    chk("sat_inserted", 32'(inserted_total), 32'd1048575);
    tick();
    busy = 1'b1;
    tick();
    #1;
    chk("t6_collect_code", {29'd0, product_code}, 32'd4);

    // 6: reset during COLLECT
    rst_n = 1'b0;
    #1;
    chk("t6_rst_code", {29'd0, product_code}, 32'd0);
    chk("t6_rst_inserted", 32'(inserted_total), 32'd0);
    chk("t6_rst_coin_ready", {31'd0, coin_ready}, 32'd0);
    chk("t6_rst_done", {31'd0, done}, 32'd0);
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    coin(4'd14, 1'b1, 3'd0);
    chk("t6_new_inserted", 32'(inserted_total), 32'd1);
    chk("t6_new_change", 32'(change_total), 32'd0);
    chk("t6_new_buy", {31'd0, buy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
